// File: rtl/cache_bus_pkg.sv
// -----------------------------------------------------------------------------
// cache_bus_pkg
// Shared types and helpers for the cache-to-AXI line fill path.
//   fill_state_e        : line fill FSM states (IDLE, ADDR, DATA, RESP)
//   LINE_BEATS_DEFAULT  : default beats per cache line
//   line_bits()         : line width in bits for a given beat count/width
//   offset_bits()       : number of byte-offset bits inside one line
//   BURST_INCR, SIZE_8B : fixed AXI encodings used for every fill burst
// -----------------------------------------------------------------------------
package cache_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } fill_state_e;

    localparam int unsigned LINE_BEATS_DEFAULT = 8;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_8B    = 3'd3;

    function automatic int unsigned line_bits(input int unsigned beats, input int unsigned beat_w);
        return beats * beat_w;
    endfunction

    function automatic int unsigned offset_bits(input int unsigned beats, input int unsigned beat_w);
        return $clog2((beats * beat_w) / 8);
    endfunction

endpackage

// File: rtl/line_fill_engine_arb.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin arbiter. A lone requester always wins; on a tie the
// requester that did not win last time is chosen. last_grant resets to 1 so
// requestor 0 wins the first tie after reset.
//   clk, reset   : clock, synchronous active-high reset
//   req_i[1:0]   : request per requestor
//   en_i         : arbitration allowed this cycle (grant is consumed)
//   gnt_valid_o  : a grant is issued this cycle
//   gnt_idx_o    : index of the granted requestor
// -----------------------------------------------------------------------------
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic       gnt_valid_o,
    output logic       gnt_idx_o
);

    logic last_grant_q;
    logic last_grant_d;

    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    always_comb begin
        gnt_valid_o  = en_i && (|req_i);
        gnt_idx_o    = (req_i == 2'b11) ? ~last_grant_q : req_i[1];
        last_grant_d = gnt_valid_o ? gnt_idx_o : last_grant_q;
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/line_fill_engine.sv
// -----------------------------------------------------------------------------
// line_fill_engine
// Serves cache-line misses from the data cache (requestor 0) and instruction
// cache (requestor 1) with one AXI INCR read burst per miss, assembling the
// beats into a full line. One burst outstanding at a time.
//
// Optional build macro: SNOOP_INVALIDATE_EN adds a snoop/invalidate channel
// and a stale flag that marks a delivered line as not installable.
//
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   req_valid_i[1:0]   : miss request (bit0 data cache, bit1 instruction cache)
//   req_addr_i         : miss address per requestor ([ADDR_WIDTH-1:0] = req 0)
//   req_ready_o[1:0]   : one-cycle accept pulse
//   resp_valid_o[1:0]  : one-cycle line-delivered pulse
//   resp_line_o        : assembled line, beat 0 in the LSBs
//   bus_err_o          : sticky error (bad rresp or misplaced rlast)
//   m_axi_ar*          : AXI read address channel (master side)
//   m_axi_r*           : AXI read data channel (master side)
//   ac_valid_i, ac_addr_i, ac_ready_o      : snoop input   (macro only)
//   inv_valid_o, inv_addr_o, resp_stale_o  : invalidate out (macro only)
// -----------------------------------------------------------------------------
module line_fill_engine
    import cache_bus_pkg::*;
#(
    parameter int ID_WIDTH   = 13,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int LINE_BEATS = LINE_BEATS_DEFAULT
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic [1:0]                                  req_valid_i,
    input  logic [2*ADDR_WIDTH-1:0]                     req_addr_i,
    output logic [1:0]                                  req_ready_o,
    output logic [1:0]                                  resp_valid_o,
    output logic [line_bits(LINE_BEATS, DATA_WIDTH)-1:0] resp_line_o,
    output logic                                        bus_err_o,
`ifdef SNOOP_INVALIDATE_EN
    input  logic                                        ac_valid_i,
    input  logic [ADDR_WIDTH-1:0]                       ac_addr_i,
    output logic                                        ac_ready_o,
    output logic                                        inv_valid_o,
    output logic [ADDR_WIDTH-1:0]                       inv_addr_o,
    output logic                                        resp_stale_o,
`endif
    output logic [ID_WIDTH-1:0]                         m_axi_arid_o,
    output logic [ADDR_WIDTH-1:0]                       m_axi_araddr_o,
    output logic [7:0]                                  m_axi_arlen_o,
    output logic [2:0]                                  m_axi_arsize_o,
    output logic [1:0]                                  m_axi_arburst_o,
    output logic                                        m_axi_arvalid_o,
    input  logic                                        m_axi_arready_i,
    input  logic [ID_WIDTH-1:0]                         m_axi_rid_i,
    input  logic [DATA_WIDTH-1:0]                       m_axi_rdata_i,
    input  logic [1:0]                                  m_axi_rresp_i,
    input  logic                                        m_axi_rlast_i,
    input  logic                                        m_axi_rvalid_i,
    output logic                                        m_axi_rready_o
);

    localparam int LINE_W   = line_bits(LINE_BEATS, DATA_WIDTH);
    localparam int OFF_BITS = offset_bits(LINE_BEATS, DATA_WIDTH);
    // One extra bit so the beat counter can sit at LINE_BEATS (saturated).
    localparam int CNT_W    = $clog2(LINE_BEATS) + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LINE_BEATS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_BEATS - 1);

    function automatic logic [ADDR_WIDTH-1:0] line_align(input logic [ADDR_WIDTH-1:0] a);
        line_align               = a;
        line_align[OFF_BITS-1:0] = '0;
    endfunction

    fill_state_e             state_q, state_d;
    logic                    grant_q, grant_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [LINE_W-1:0]       line_q, line_d;
    logic                    bus_err_q, bus_err_d;

    logic                    gnt_valid;
    logic                    gnt_idx;
    logic [ADDR_WIDTH-1:0]   gnt_addr;

    // Read ID is not checked: only one burst is ever outstanding.
    logic unused_rid;
    assign unused_rid = ^m_axi_rid_i;

    rr_arbiter2 u_arb (
        .clk         (clk),
        .reset       (reset),
        .req_i       (req_valid_i),
        .en_i        (state_q == IDLE),
        .gnt_valid_o (gnt_valid),
        .gnt_idx_o   (gnt_idx)
    );

    assign gnt_addr = gnt_idx ? req_addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH]
                              : req_addr_i[ADDR_WIDTH-1:0];

    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        addr_d          = addr_q;
        cnt_d           = cnt_q;
        line_d          = line_q;
        bus_err_d       = bus_err_q;
        req_ready_o     = '0;
        resp_valid_o    = '0;
        m_axi_arvalid_o = 1'b0;
        m_axi_rready_o  = 1'b0;

        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    req_ready_o[gnt_idx] = 1'b1;
                    grant_d              = gnt_idx;
                    addr_d               = line_align(gnt_addr);
                    state_d              = ADDR;
                end
            end
            ADDR: begin
                m_axi_arvalid_o = 1'b1;
                if (m_axi_arready_i) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                m_axi_rready_o = 1'b1;
                if (m_axi_rvalid_i) begin
                    // Beats past the end of the line are dropped; the counter
                    // saturates so they can never wrap onto slot 0.
                    if (cnt_q < CNT_FULL) begin
                        line_d[cnt_q[CNT_W-2:0]*DATA_WIDTH +: DATA_WIDTH] = m_axi_rdata_i;
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (m_axi_rresp_i != 2'b00) begin
                        bus_err_d = 1'b1;
                    end
                    if (m_axi_rlast_i) begin
                        if (cnt_q != CNT_LAST) begin
                            bus_err_d = 1'b1;
                        end
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                resp_valid_o[grant_q] = 1'b1;
                cnt_d                 = '0;
                state_d               = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Handshake outputs drop in the reset cycle itself, not one cycle later.
        if (reset) begin
            req_ready_o     = '0;
            resp_valid_o    = '0;
            m_axi_arvalid_o = 1'b0;
            m_axi_rready_o  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            grant_q   <= 1'b0;
            addr_q    <= '0;
            cnt_q     <= '0;
            // NOTE: line_q is a flop vector rather than a RAM, so it can be reset to a defined zero line.
            line_q    <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            line_q    <= line_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign resp_line_o     = line_q;
    assign bus_err_o       = bus_err_q;
    assign m_axi_arid_o    = {{(ID_WIDTH-1){1'b0}}, grant_q};
    assign m_axi_araddr_o  = addr_q;
    assign m_axi_arlen_o   = 8'(LINE_BEATS - 1);
    assign m_axi_arsize_o  = SIZE_8B;
    assign m_axi_arburst_o = BURST_INCR;

`ifdef SNOOP_INVALIDATE_EN
    logic                  stale_q, stale_d;
    logic                  inv_valid_q;
    logic [ADDR_WIDTH-1:0] inv_addr_q;

    // A snoop hitting the line being fetched makes the delivered copy stale.
    always_comb begin
        stale_d = stale_q;
        if (state_q == IDLE) begin
            stale_d = 1'b0;
        end else if ((state_q == ADDR || state_q == DATA) && ac_valid_i &&
                     (line_align(ac_addr_i) == addr_q)) begin
            stale_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stale_q     <= 1'b0;
            inv_valid_q <= 1'b0;
            inv_addr_q  <= '0;
        end else begin
            stale_q     <= stale_d;
            inv_valid_q <= ac_valid_i;
            if (ac_valid_i) begin
                inv_addr_q <= line_align(ac_addr_i);
            end
        end
    end

    assign ac_ready_o   = 1'b1;
    assign inv_valid_o  = inv_valid_q;
    assign inv_addr_o   = inv_addr_q;
    assign resp_stale_o = (state_q == RESP) && stale_q && !reset;
`endif

endmodule

// File: tb/tb_line_fill_engine.sv
// -----------------------------------------------------------------------------
// tb_line_fill_engine
// Directed self-checking bench for line_fill_engine. Acts as both caches and
// as the AXI slave. Inputs change on the falling edge; outputs are sampled on
// the falling edge (or 1 time unit after an input change for combinational
// handshakes). Snoop scenario is built only with SNOOP_INVALIDATE_EN.
// -----------------------------------------------------------------------------
module tb_line_fill_engine;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int IW = 13;
    localparam int LB = 8;
    localparam int LW = LB * DW;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [1:0]      req_valid = '0;
    logic [2*AW-1:0] req_addr = '0;
    logic [1:0]      req_ready;
    logic [1:0]      resp_valid;
    logic [LW-1:0]   resp_line;
    logic            bus_err;
    logic [IW-1:0]   m_axi_arid;
    logic [AW-1:0]   m_axi_araddr;
    logic [7:0]      m_axi_arlen;
    logic [2:0]      m_axi_arsize;
    logic [1:0]      m_axi_arburst;
    logic            m_axi_arvalid;
    logic            m_axi_arready = 1'b0;
    logic [IW-1:0]   m_axi_rid = '0;
    logic [DW-1:0]   m_axi_rdata = '0;
    logic [1:0]      m_axi_rresp = '0;
    logic            m_axi_rlast = 1'b0;
    logic            m_axi_rvalid = 1'b0;
    logic            m_axi_rready;
`ifdef SNOOP_INVALIDATE_EN
    logic            ac_valid = 1'b0;
    logic [AW-1:0]   ac_addr = '0;
    logic            ac_ready;
    logic            inv_valid;
    logic [AW-1:0]   inv_addr;
    logic            resp_stale;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [LW-1:0] model_line = '0;

    always #5 clk = ~clk;

    line_fill_engine dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid_i     (req_valid),
        .req_addr_i      (req_addr),
        .req_ready_o     (req_ready),
        .resp_valid_o    (resp_valid),
        .resp_line_o     (resp_line),
        .bus_err_o       (bus_err),
`ifdef SNOOP_INVALIDATE_EN
        .ac_valid_i      (ac_valid),
        .ac_addr_i       (ac_addr),
        .ac_ready_o      (ac_ready),
        .inv_valid_o     (inv_valid),
        .inv_addr_o      (inv_addr),
        .resp_stale_o    (resp_stale),
`endif
        .m_axi_arid_o    (m_axi_arid),
        .m_axi_araddr_o  (m_axi_araddr),
        .m_axi_arlen_o   (m_axi_arlen),
        .m_axi_arsize_o  (m_axi_arsize),
        .m_axi_arburst_o (m_axi_arburst),
        .m_axi_arvalid_o (m_axi_arvalid),
        .m_axi_arready_i (m_axi_arready),
        .m_axi_rid_i     (m_axi_rid),
        .m_axi_rdata_i   (m_axi_rdata),
        .m_axi_rresp_i   (m_axi_rresp),
        .m_axi_rlast_i   (m_axi_rlast),
        .m_axi_rvalid_i  (m_axi_rvalid),
        .m_axi_rready_o  (m_axi_rready)
    );

    // Beat i of a burst carries pat*(i+1): pat=0x11 gives 0x11, 0x22 .. 0x88.
    function automatic logic [DW-1:0] beat_val(input logic [DW-1:0] pat, input int i);
        return pat * 64'(i + 1);
    endfunction

    // Expected line after the first nw beats of a burst land on top of prev.
    function automatic logic [LW-1:0] exp_line(input logic [DW-1:0] pat, input int nw,
                                               input logic [LW-1:0] prev);
        exp_line = prev;
        for (int i = 0; i < LB; i++) begin
            if (i < nw) exp_line[i*DW +: DW] = beat_val(pat, i);
        end
    endfunction

    task automatic apply_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_line = '0;
    endtask

    task automatic request(input logic [1:0] v, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                           output logic [1:0] rdy);
        req_valid = v;
        req_addr  = {a1, a0};
        #1;
        rdy = req_ready;
    endtask

    // Waits (bounded) for arvalid, records the request and completes the handshake.
    task automatic wait_ar(output logic ok, output int waited,
                           output logic [AW-1:0] addr, output logic [IW-1:0] id);
        ok = 1'b0;
        waited = 0;
        addr = '0;
        id = '0;
        while (!ok && waited < 20) begin
            if (m_axi_arvalid === 1'b1) ok = 1'b1;
            else begin
                waited++;
                @(negedge clk);
            end
        end
        if (ok) begin
            addr = m_axi_araddr;
            id   = m_axi_arid;
            m_axi_arready = 1'b1;
            @(negedge clk);
            m_axi_arready = 1'b0;
        end
    endtask

    // Drives beats first..first+n-1 back to back; returns at the falling edge
    // after the last beat was accepted.
    task automatic send_beats(input logic [DW-1:0] pat, input int first, input int n,
                              input int last_at, input int err_at, output logic ar_seen);
        ar_seen = 1'b0;
        for (int i = first; i < first + n; i++) begin
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = beat_val(pat, i);
            m_axi_rlast  = (i == last_at);
            m_axi_rresp  = (i == err_at) ? 2'b10 : 2'b00;
            @(negedge clk);
            if (m_axi_arvalid === 1'b1) ar_seen = 1'b1;
        end
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        m_axi_rresp  = 2'b00;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if ({req_ready, resp_valid, m_axi_arvalid, m_axi_rready} !== 6'b0) begin
            n_fail++; $display("FAIL reset_handshake: got %b want 000000", {req_ready, resp_valid, m_axi_arvalid, m_axi_rready}); end
        reset = 1'b0;
        model_line = '0;
        @(negedge clk);
        n_checks++; if (resp_line !== '0) begin
            n_fail++; $display("FAIL reset_line: got %h want 0", resp_line); end
        n_checks++; if (bus_err !== 1'b0 || m_axi_arvalid !== 1'b0) begin
            n_fail++; $display("FAIL reset_err_arvalid: got %b%b want 00", bus_err, m_axi_arvalid); end
    endtask

    task automatic test_single_miss();
        logic [1:0] rdy; logic ok; int w; logic [AW-1:0] a; logic [IW-1:0] id; logic ars;
        logic [LW-1:0] exp;
        request(2'b01, 64'h8000_0123, 64'h0, rdy);
        n_checks++; if (rdy !== 2'b01) begin n_fail++; $display("FAIL single_rdy: got %b want 01", rdy); end
        @(negedge clk);
        req_valid = 2'b00;
        n_checks++; if ({m_axi_arlen, m_axi_arsize, m_axi_arburst} !== {8'd7, 3'd3, 2'b01}) begin
            n_fail++; $display("FAIL single_arfields: got len=%0d size=%0d burst=%b want 7 3 01", m_axi_arlen, m_axi_arsize, m_axi_arburst); end
        wait_ar(ok, w, a, id);
        n_checks++; if (!ok || w != 0) begin n_fail++; $display("FAIL single_ar_latency: got ok=%b wait=%0d want 1 0", ok, w); end
        n_checks++; if (a !== 64'h8000_0100 || id !== '0) begin
            n_fail++; $display("FAIL single_araddr: got %h id %0d want 80000100 id 0", a, id); end
        send_beats(64'h11, 0, 8, 7, -1, ars);
        exp = exp_line(64'h11, 8, model_line);
        n_checks++; if (resp_valid !== 2'b01) begin n_fail++; $display("FAIL single_resp: got %b want 01", resp_valid); end
        n_checks++; if (resp_line !== exp || resp_line[63:0] !== 64'h11) begin
            n_fail++; $display("FAIL single_line: got %h want %h", resp_line, exp); end
        n_checks++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL single_err: got %b want 0", bus_err); end
        model_line = exp;
        @(negedge clk);
        n_checks++; if (resp_valid !== 2'b00) begin n_fail++; $display("FAIL single_resp_pulse: got %b want 00", resp_valid); end
    endtask

    task automatic test_tie();
        logic [1:0] rdy; logic ok; int w; logic [AW-1:0] a; logic [IW-1:0] id; logic ars;
        apply_reset();
        request(2'b11, 64'h1000, 64'h2040, rdy);
        n_checks++; if (rdy !== 2'b01) begin n_fail++; $display("FAIL tie_first: got %b want 01", rdy); end
        @(negedge clk);
        req_valid = 2'b10;
        n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL tie_busy_rdy: got %b want 00", req_ready); end
        wait_ar(ok, w, a, id);
        n_checks++; if (!ok || a !== 64'h1000 || id !== 13'd0) begin
            n_fail++; $display("FAIL tie_d_ar: got ok=%b %h id %0d want 1 1000 0", ok, a, id); end
        send_beats(64'h0101, 0, 8, 7, -1, ars);
        n_checks++; if (resp_valid !== 2'b01 || req_ready !== 2'b00) begin
            n_fail++; $display("FAIL tie_d_resp: got resp=%b rdy=%b want 01 00", resp_valid, req_ready); end
        @(negedge clk);
        n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL tie_i_grant: got %b want 10", req_ready); end
        @(negedge clk);
        req_valid = 2'b00;
        wait_ar(ok, w, a, id);
        n_checks++; if (!ok || a !== 64'h2040 || id !== 13'd1) begin
            n_fail++; $display("FAIL tie_i_ar: got ok=%b %h id %0d want 1 2040 1", ok, a, id); end
        send_beats(64'h0202, 0, 8, 7, -1, ars);
        n_checks++; if (resp_valid !== 2'b10 || resp_line !== exp_line(64'h0202, 8, model_line)) begin
            n_fail++; $display("FAIL tie_i_resp: got resp=%b line %h", resp_valid, resp_line); end
        model_line = exp_line(64'h0202, 8, model_line);
        @(negedge clk);
        request(2'b11, 64'h3000, 64'h4000, rdy);
        n_checks++; if (rdy !== 2'b01) begin n_fail++; $display("FAIL tie_second: got %b want 01", rdy); end
        @(negedge clk);
        req_valid = 2'b00;
        wait_ar(ok, w, a, id);
        send_beats(64'h0303, 0, 8, 7, -1, ars);
        model_line = exp_line(64'h0303, 8, model_line);
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [1:0] rdy; logic ok; int w; logic [AW-1:0] a; logic [IW-1:0] id; logic ars;
        request(2'b01, 64'h5000, 64'h6000, rdy);
        n_checks++; if (rdy !== 2'b01) begin n_fail++; $display("FAIL b2b_d_rdy: got %b want 01", rdy); end
        @(negedge clk);
        req_valid = 2'b00;
        wait_ar(ok, w, a, id);
        req_valid = 2'b10;
        send_beats(64'h0404, 0, 8, 7, -1, ars);
        model_line = exp_line(64'h0404, 8, model_line);
        n_checks++; if (ars !== 1'b0 || m_axi_arvalid !== 1'b0 || resp_valid !== 2'b01) begin
            n_fail++; $display("FAIL b2b_hold: got ar_seen=%b arvalid=%b resp=%b want 0 0 01", ars, m_axi_arvalid, resp_valid); end
        req_valid = 2'b11;
        @(negedge clk);
        n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL b2b_i_next: got %b want 10", req_ready); end
        @(negedge clk);
        req_valid = 2'b01;
        wait_ar(ok, w, a, id);
        n_checks++; if (!ok || w != 0 || id !== 13'd1 || a !== 64'h6000) begin
            n_fail++; $display("FAIL b2b_i_ar: got ok=%b wait=%0d id %0d %h want 1 0 1 6000", ok, w, id, a); end
        send_beats(64'h0505, 0, 8, 7, -1, ars);
        model_line = exp_line(64'h0505, 8, model_line);
        @(negedge clk);
        n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL b2b_d_again: got %b want 01", req_ready); end
        @(negedge clk);
        req_valid = 2'b00;
        wait_ar(ok, w, a, id);
        send_beats(64'h0606, 0, 8, 7, -1, ars);
        n_checks++; if (resp_valid !== 2'b01 || resp_line !== exp_line(64'h0606, 8, model_line)) begin
            n_fail++; $display("FAIL b2b_d_resp: got resp=%b line %h", resp_valid, resp_line); end
        model_line = exp_line(64'h0606, 8, model_line);
        @(negedge clk);
    endtask

    task automatic test_rresp_err();
        logic [1:0] rdy; logic ok; int w; logic [AW-1:0] a; logic [IW-1:0] id; logic ars;
        apply_reset();
        request(2'b01, 64'h7000, 64'h0, rdy);
        @(negedge clk);
        req_valid = 2'b00;
        wait_ar(ok, w, a, id);
        send_beats(64'h0707, 0, 8, 7, 3, ars);
        n_checks++; if (resp_valid !== 2'b01 || bus_err !== 1'b1) begin
            n_fail++; $display("FAIL rresp_err: got resp=%b err=%b want 01 1", resp_valid, bus_err); end
        n_checks++; if (resp_line !== exp_line(64'h0707, 8, model_line)) begin
            n_fail++; $display("FAIL rresp_line: got %h want %h", resp_line, exp_line(64'h0707, 8, model_line)); end
        model_line = exp_line(64'h0707, 8, model_line);
        @(negedge clk);
        request(2'b10, 64'h0, 64'h7040, rdy);
        @(negedge clk);
        req_valid = 2'b00;
        wait_ar(ok, w, a, id);
        send_beats(64'h0808, 0, 8, 7, -1, ars);
        n_checks++; if (resp_valid !== 2'b10 || bus_err !== 1'b1) begin
            n_fail++; $display("FAIL rresp_sticky: got resp=%b err=%b want 10 1", resp_valid, bus_err); end
        @(negedge clk);
    endtask

    task automatic test_rlast_and_overflow();
        logic [1:0] rdy; logic ok; int w; logic [AW-1:0] a; logic [IW-1:0] id; logic ars;
        apply_reset();
        n_checks++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL err_cleared: got %b want 0", bus_err); end
        request(2'b01, 64'h8000, 64'h0, rdy);
        @(negedge clk);
        req_valid = 2'b00;
        wait_ar(ok, w, a, id);
        send_beats(64'h0909, 0, 6, 5, -1, ars);
        n_checks++; if (resp_valid !== 2'b01 || bus_err !== 1'b1) begin
            n_fail++; $display("FAIL early_rlast: got resp=%b err=%b want 01 1", resp_valid, bus_err); end
        n_checks++; if (resp_line !== exp_line(64'h0909, 6, model_line)) begin
            n_fail++; $display("FAIL early_line: got %h want %h", resp_line, exp_line(64'h0909, 6, model_line)); end
        @(negedge clk);
        apply_reset();
        request(2'b01, 64'h9000, 64'h0, rdy);
        @(negedge clk);
        req_valid = 2'b00;
        wait_ar(ok, w, a, id);
        send_beats(64'h0a0a, 0, 10, 9, -1, ars);
        n_checks++; if (resp_valid !== 2'b01 || bus_err !== 1'b1) begin
            n_fail++; $display("FAIL overflow_resp: got resp=%b err=%b want 01 1", resp_valid, bus_err); end
        n_checks++; if (resp_line !== exp_line(64'h0a0a, 8, model_line)) begin
            n_fail++; $display("FAIL overflow_line: got %h want %h", resp_line, exp_line(64'h0a0a, 8, model_line)); end
        model_line = exp_line(64'h0a0a, 8, model_line);
        @(negedge clk);
    endtask

    task automatic test_reset_mid_burst();
        logic [1:0] rdy; logic ok; int w; logic [AW-1:0] a; logic [IW-1:0] id; logic ars;
        logic resp_seen;
        apply_reset();
        request(2'b01, 64'hA000, 64'h0, rdy);
        @(negedge clk);
        req_valid = 2'b00;
        wait_ar(ok, w, a, id);
        send_beats(64'h0b0b, 0, 4, -1, -1, ars);
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = beat_val(64'h0b0b, 4);
        reset = 1'b1;
        #1;
        n_checks++; if ({m_axi_arvalid, m_axi_rready, resp_valid} !== 4'b0) begin
            n_fail++; $display("FAIL midrst_outputs: got %b want 0000", {m_axi_arvalid, m_axi_rready, resp_valid}); end
        @(negedge clk);
        m_axi_rvalid = 1'b0;
        reset = 1'b0;
        model_line = '0;
        n_checks++; if (resp_line !== '0 || bus_err !== 1'b0) begin
            n_fail++; $display("FAIL midrst_state: got err=%b line %h want 0 0", bus_err, resp_line); end
        resp_seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (resp_valid !== 2'b00 || m_axi_rready !== 1'b0) resp_seen = 1'b1;
        end
        n_checks++; if (resp_seen !== 1'b0) begin n_fail++; $display("FAIL midrst_quiet: got activity=%b want 0", resp_seen); end
        request(2'b10, 64'h0, 64'hB000, rdy);
        n_checks++; if (rdy !== 2'b10) begin n_fail++; $display("FAIL midrst_new_rdy: got %b want 10", rdy); end
        @(negedge clk);
        req_valid = 2'b00;
        wait_ar(ok, w, a, id);
        send_beats(64'h0c0c, 0, 8, 7, -1, ars);
        n_checks++; if (resp_valid !== 2'b10 || resp_line !== exp_line(64'h0c0c, 8, model_line) || bus_err !== 1'b0) begin
            n_fail++; $display("FAIL midrst_new_fill: got resp=%b err=%b line %h", resp_valid, bus_err, resp_line); end
        model_line = exp_line(64'h0c0c, 8, model_line);
        @(negedge clk);
    endtask

`ifdef SNOOP_INVALIDATE_EN
    task automatic test_snoop();
        logic [1:0] rdy; logic ok; int w; logic [AW-1:0] a; logic [IW-1:0] id; logic ars;
        request(2'b01, 64'hC000, 64'h0, rdy);
        @(negedge clk);
        req_valid = 2'b00;
        wait_ar(ok, w, a, id);
        ac_valid = 1'b1;
        ac_addr  = 64'hC018;
        @(negedge clk);
        ac_valid = 1'b0;
        n_checks++; if (inv_valid !== 1'b1 || inv_addr !== 64'hC000 || ac_ready !== 1'b1) begin
            n_fail++; $display("FAIL snoop_inv: got v=%b addr %h rdy=%b want 1 c000 1", inv_valid, inv_addr, ac_ready); end
        send_beats(64'h0d0d, 0, 8, 7, -1, ars);
        n_checks++; if (resp_valid !== 2'b01 || resp_stale !== 1'b1) begin
            n_fail++; $display("FAIL snoop_stale: got resp=%b stale=%b want 01 1", resp_valid, resp_stale); end
        @(negedge clk);
        request(2'b01, 64'hD000, 64'h0, rdy);
        @(negedge clk);
        req_valid = 2'b00;
        wait_ar(ok, w, a, id);
        send_beats(64'h0e0e, 0, 8, 7, -1, ars);
        n_checks++; if (resp_valid !== 2'b01 || resp_stale !== 1'b0) begin
            n_fail++; $display("FAIL snoop_clean: got resp=%b stale=%b want 01 0", resp_valid, resp_stale); end
        @(negedge clk);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_miss();
        test_tie();
        test_back_to_back();
        test_rresp_err();
        test_rlast_and_overflow();
        test_reset_mid_burst();
`ifdef SNOOP_INVALIDATE_EN
        test_snoop();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
